// File: rtl/user_obi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// user_obi_rr_arbiter
//   Shares one single-port OBI subordinate (e.g. the user-domain ROM) between
//   NumMgr OBI managers. Round-robin arbitration, at most one transaction in
//   flight, responses routed back to the manager that was granted.
//
// Ports
//   clk_i          clock, posedge
//   rst_ni         asynchronous active-low reset
//   mgr_req_i      OBI requests from the managers
//   mgr_rsp_o      OBI responses to the managers
//   sbr_req_o      OBI request to the shared subordinate
//   sbr_rsp_i      OBI response from the shared subordinate
//   busy_o         1 while a transaction is outstanding
//   spurious_rsp_o 1-cycle pulse: rvalid arrived with nothing outstanding
// ---------------------------------------------------------------------------
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam int unsigned ObiAddrW = 32;
  localparam int unsigned ObiDataW = 32;
  localparam int unsigned ObiIdW   = 4;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: ObiAddrW,
    DataWidth: ObiDataW,
    IdWidth:   ObiIdW
  };

  typedef struct packed {
    logic [ObiAddrW-1:0]   addr;
    logic                  we;
    logic [ObiDataW/8-1:0] be;
    logic [ObiDataW-1:0]   wdata;
    logic [ObiIdW-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic [ObiDataW-1:0] rdata;
    logic [ObiIdW-1:0]   rid;
    logic                err;
    logic                r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// state | meaning
// IDLE  | nothing outstanding at the subordinate
// BUSY  | one granted transaction awaits its rvalid; owner_q holds the manager
module user_obi_rr_arbiter #(
  parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned       NumMgr    = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t mgr_req_i [NumMgr],
  output obi_rsp_t mgr_rsp_o [NumMgr],
  output obi_req_t sbr_req_o,
  input  obi_rsp_t sbr_rsp_i,
  output logic     busy_o,
  output logic     spurious_rsp_o
);

  localparam int unsigned IdxW = $clog2(NumMgr);

  // ObiCfg only sizes the struct types; reject nonsensical builds early.
  if (NumMgr < 2 || NumMgr > 4 || ObiCfg.IdWidth == 0) begin : g_bad_cfg
    $error("user_obi_rr_arbiter: unsupported configuration");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic              lock_q, lock_d;
  logic [IdxW-1:0]   lidx_q, lidx_d;
  logic              busy_q, busy_d;
  logic              spurious_q, spurious_d;

  logic [NumMgr-1:0] req_vec;
  logic [IdxW-1:0]   winner;
  logic              found;
  int unsigned       idx;
  logic              can_issue;
  logic              issue;
  logic              handshake;
  logic              rsp_valid;

  always_comb begin
    req_vec = '0;
    for (int unsigned i = 0; i < NumMgr; i++) begin
      req_vec[i] = mgr_req_i[i].req;
    end
  end

  // Scan starts just after the last winner; a stalled request keeps its slot.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= NumMgr; i++) begin
      idx = (int'(rr_q) + i) % NumMgr;
      if (!found && req_vec[IdxW'(idx)]) begin
        winner = IdxW'(idx);
        found  = 1'b1;
      end
    end
    if (lock_q) begin
      winner = lidx_q;
    end
  end

  // Issue is allowed in the response cycle so back-to-back grants lose no cycle.
  assign can_issue = (state_q == IDLE) | ((state_q == BUSY) & sbr_rsp_i.rvalid);
  assign issue     = can_issue & req_vec[winner];
  assign handshake = issue & sbr_rsp_i.gnt;
  assign rsp_valid = sbr_rsp_i.rvalid & (state_q == BUSY);

  always_comb begin
    sbr_req_o     = mgr_req_i[winner];
    sbr_req_o.req = issue;
  end

  always_comb begin
    for (int unsigned i = 0; i < NumMgr; i++) begin
      mgr_rsp_o[i]        = '0;
      mgr_rsp_o[i].r      = sbr_rsp_i.r;
      mgr_rsp_o[i].gnt    = handshake & (winner == IdxW'(i));
      mgr_rsp_o[i].rvalid = rsp_valid & (owner_q == IdxW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    lidx_d     = lidx_q;
    if (handshake) begin
      state_d = BUSY;
      owner_d = winner;
      rr_d    = winner;
      lock_d  = 1'b0;
    end else begin
      if (issue) begin
        lock_d = 1'b1;
        lidx_d = winner;
      end
      if (rsp_valid) begin
        state_d = IDLE;
      end
    end
    busy_d     = (state_d == BUSY);
    spurious_d = sbr_rsp_i.rvalid & (state_q == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= IdxW'(NumMgr - 1);
      lock_q     <= 1'b0;
      lidx_q     <= '0;
      busy_q     <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lidx_q     <= lidx_d;
      busy_q     <= busy_d;
      spurious_q <= spurious_d;
    end
  end

  assign busy_o         = busy_q;
  assign spurious_rsp_o = spurious_q;

endmodule

// File: tb/tb_user_obi_rr_arbiter.sv
// Bench for user_obi_rr_arbiter with two managers and a 1-cycle ROM subordinate.
module tb_user_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int NM = 2;

  logic     clk;
  logic     rst_n;
  obi_req_t mgr_req [NM];
  obi_rsp_t mgr_rsp [NM];
  obi_req_t sbr_req;
  obi_rsp_t sbr_rsp;
  logic     busy_o;
  logic     spurious_rsp_o;

  user_obi_rr_arbiter #(.NumMgr(NM)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mgr_req_i     (mgr_req),
    .mgr_rsp_o     (mgr_rsp),
    .sbr_req_o     (sbr_req),
    .sbr_rsp_i     (sbr_rsp),
    .busy_o        (busy_o),
    .spurious_rsp_o(spurious_rsp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    case (addr[3:2])
      2'd0:    return 32'h7567694d;
      2'd1:    return 32'h43206c65;
      2'd2:    return 32'h6f72706d;
      default: return 32'h00000000;
    endcase
  endfunction

  // Reference model: transaction-level view of the arbiter.
  bit          m_busy, m_lock, m_spur;
  int          m_owner, m_last, m_lidx;
  logic [31:0] m_rdata;
  logic [3:0]  m_rid;
  logic        m_err;

  // Subordinate (ROM) model.
  bit          rsp_pend, force_rv, sub_gnt;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_rid;
  logic        rsp_err;

  // Per-cycle samples for directed checks.
  bit          g_seen [NM];
  bit          rv_seen [NM];
  logic [31:0] s_rdata [NM];
  logic [3:0]  s_rid [NM];
  logic        s_err [NM];
  logic        s_busy, s_spur;
  logic [31:0] s_saddr;

  task automatic model_reset();
    m_busy  = 0;
    m_lock  = 0;
    m_spur  = 0;
    m_owner = 0;
    m_last  = NM - 1;
    m_lidx  = 0;
  endtask

  // Requesting manager closest after the last winner, or the stalled one.
  function automatic int exp_winner();
    int best, bestd, d;
    if (m_lock) return m_lidx;
    best  = -1;
    bestd = NM + 1;
    for (int i = 0; i < NM; i++) begin
      d = (i - m_last - 1 + 2 * NM) % NM;
      if (mgr_req[i].req && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic cycle();
    int   w;
    bit   can, ereq, hs, rv_in, eg, erv;
    sbr_rsp.gnt    = sub_gnt;
    sbr_rsp.rvalid = rsp_pend | force_rv;
    if (rsp_pend) begin
      sbr_rsp.r.rdata = rsp_rdata;
      sbr_rsp.r.rid   = rsp_rid;
      sbr_rsp.r.err   = rsp_err;
    end else begin
      sbr_rsp.r.rdata = $urandom;
      sbr_rsp.r.rid   = 4'($urandom);
      sbr_rsp.r.err   = 1'b0;
    end
    sbr_rsp.r.r_optional = 1'b0;
    #1;
    rv_in = sbr_rsp.rvalid;
    w     = exp_winner();
    can   = !m_busy || rv_in;
    ereq  = can && (w >= 0) && mgr_req[(w < 0) ? 0 : w].req;
    hs    = ereq && sub_gnt;
    check_val("busy", busy_o, m_busy);
    check_val("spurious", spurious_rsp_o, m_spur);
    check_val("sbr_req", sbr_req.req, ereq);
    if (ereq) begin
      check_val("sbr_addr", sbr_req.a.addr, mgr_req[w].a.addr);
      check_val("sbr_aid", sbr_req.a.aid, mgr_req[w].a.aid);
    end
    check_val("rdata_pass", mgr_rsp[NM-1].r.rdata, sbr_rsp.r.rdata);
    for (int i = 0; i < NM; i++) begin
      eg  = hs && (i == w);
      erv = m_busy && rv_in && (i == m_owner);
      check_val($sformatf("gnt%0d", i), mgr_rsp[i].gnt, eg);
      check_val($sformatf("rvalid%0d", i), mgr_rsp[i].rvalid, erv);
      if (erv) begin
        check_val($sformatf("rdata%0d", i), mgr_rsp[i].r.rdata, m_rdata);
        check_val($sformatf("rid%0d", i), mgr_rsp[i].r.rid, m_rid);
        check_val($sformatf("err%0d", i), mgr_rsp[i].r.err, m_err);
      end
      g_seen[i]  = mgr_rsp[i].gnt;
      rv_seen[i] = mgr_rsp[i].rvalid;
      s_rdata[i] = mgr_rsp[i].r.rdata;
      s_rid[i]   = mgr_rsp[i].r.rid;
      s_err[i]   = mgr_rsp[i].r.err;
    end
    s_busy  = busy_o;
    s_spur  = spurious_rsp_o;
    s_saddr = sbr_req.a.addr;
    @(posedge clk);
    #1;
    m_spur   = rv_in && !m_busy;
    rsp_pend = hs;
    if (hs) begin
      m_last    = w;
      m_owner   = w;
      m_busy    = 1;
      m_lock    = 0;
      m_rdata   = rom_word(mgr_req[w].a.addr);
      m_rid     = mgr_req[w].a.aid;
      m_err     = mgr_req[w].a.we;
      rsp_rdata = m_rdata;
      rsp_rid   = m_rid;
      rsp_err   = m_err;
    end else begin
      if (ereq) begin
        m_lock = 1;
        m_lidx = w;
      end
      if (m_busy && rv_in) m_busy = 0;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic we, input logic [3:0] aid);
    mgr_req[i].req     = 1'b1;
    mgr_req[i].a.addr  = addr;
    mgr_req[i].a.we    = we;
    mgr_req[i].a.be    = 4'hf;
    mgr_req[i].a.wdata = $urandom;
    mgr_req[i].a.aid   = aid;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check_val("rst_busy", busy_o, 1'b0);
    check_val("rst_spurious", spurious_rsp_o, 1'b0);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  int cnt0, cnt1, who;

  initial begin
    rst_n    = 1'b0;
    sbr_rsp  = '0;
    for (int i = 0; i < NM; i++) mgr_req[i] = '0;
    rsp_pend = 0;
    force_rv = 0;
    sub_gnt  = 1;
    rsp_rdata = '0;
    rsp_rid   = '0;
    rsp_err   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_dut();

    // 1: single read from mgr0
    set_req(0, 32'h0, 1'b0, 4'd3);
    cycle();
    check_val("t1_gnt0", g_seen[0], 1'b1);
    check_val("t1_gnt1", g_seen[1], 1'b0);
    mgr_req[0].req = 1'b0;
    cycle();
    check_val("t1_rv0", rv_seen[0], 1'b1);
    check_val("t1_rdata", s_rdata[0], 32'h7567694d);
    check_val("t1_rid", s_rid[0], 4'd3);
    check_val("t1_rv1", rv_seen[1], 1'b0);

    // 2: simultaneous requests from reset, back-to-back
    reset_dut();
    set_req(0, 32'h0, 1'b0, 4'd1);
    set_req(1, 32'h4, 1'b0, 4'd2);
    cycle();
    check_val("t2_gnt0", g_seen[0], 1'b1);
    check_val("t2_gnt1_first", g_seen[1], 1'b0);
    mgr_req[0].req = 1'b0;
    cycle();
    check_val("t2_gnt1_b2b", g_seen[1], 1'b1);
    check_val("t2_rv0", rv_seen[0], 1'b1);
    mgr_req[1].req = 1'b0;
    cycle();
    check_val("t2_rv1", rv_seen[1], 1'b1);
    check_val("t2_rdata1", s_rdata[1], 32'h43206c65);

    // 3: fairness under continuous requests
    set_req(0, 32'h0, 1'b0, 4'd4);
    set_req(1, 32'h4, 1'b0, 4'd5);
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      who = g_seen[0] ? 0 : (g_seen[1] ? 1 : 2);
      check_val("t3_order", who, k % 2);
      if (g_seen[0]) cnt0++;
      if (g_seen[1]) cnt1++;
      if (k > 0) check_val("t3_busy", s_busy, 1'b1);
    end
    check_val("t3_cnt0", cnt0, 4);
    check_val("t3_cnt1", cnt1, 4);
    mgr_req[0].req = 1'b0;
    mgr_req[1].req = 1'b0;
    cycle();

    // 4: stalled grant keeps mgr1 forwarded despite mgr0's priority
    sub_gnt = 0;
    set_req(1, 32'h4, 1'b0, 4'd6);
    cycle();
    check_val("t4_addr_c1", s_saddr, 32'h4);
    set_req(0, 32'h0, 1'b0, 4'd7);
    for (int k = 0; k < 2; k++) begin
      cycle();
      check_val("t4_addr_stall", s_saddr, 32'h4);
      check_val("t4_gnt0_stall", g_seen[0], 1'b0);
    end
    sub_gnt = 1;
    cycle();
    check_val("t4_gnt1", g_seen[1], 1'b1);
    check_val("t4_gnt0_late", g_seen[0], 1'b0);
    mgr_req[1].req = 1'b0;
    cycle();
    check_val("t4_gnt0", g_seen[0], 1'b1);
    mgr_req[0].req = 1'b0;
    cycle();

    // 5: spurious response while idle
    force_rv = 1;
    cycle();
    force_rv = 0;
    check_val("t5_rv0", rv_seen[0], 1'b0);
    check_val("t5_rv1", rv_seen[1], 1'b0);
    cycle();
    check_val("t5_spur_on", s_spur, 1'b1);
    cycle();
    check_val("t5_spur_off", s_spur, 1'b0);

    // 6: reset while busy, late rvalid, write error
    set_req(0, 32'h0, 1'b0, 4'd1);
    cycle();
    mgr_req[0].req = 1'b0;
    reset_dut();
    set_req(0, 32'h8, 1'b1, 4'd2);
    set_req(1, 32'h0, 1'b0, 4'd3);
    cycle();
    check_val("t6_gnt0", g_seen[0], 1'b1);
    check_val("t6_gnt1", g_seen[1], 1'b0);
    check_val("t6_late_rv0", rv_seen[0], 1'b0);
    check_val("t6_late_rv1", rv_seen[1], 1'b0);
    mgr_req[0].req = 1'b0;
    cycle();
    check_val("t6_spur", s_spur, 1'b1);
    check_val("t6_rv0", rv_seen[0], 1'b1);
    check_val("t6_err", s_err[0], 1'b1);
    check_val("t6_gnt1_b2b", g_seen[1], 1'b1);
    mgr_req[1].req = 1'b0;
    cycle();
    check_val("t6_err1", s_err[1], 1'b0);

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      sub_gnt  = ($urandom_range(0, 3) != 0);
      force_rv = !rsp_pend && ($urandom_range(0, 7) == 0);
      cycle();
      for (int i = 0; i < NM; i++) begin
        if (g_seen[i]) mgr_req[i].req = 1'b0;
        if (!mgr_req[i].req && $urandom_range(0, 2) == 0) begin
          set_req(i, {28'h0, 2'($urandom), 2'b00}, ($urandom_range(0, 4) == 0), 4'($urandom));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
